dcache_mmio_nway: RTL and testbench

Parametrised successor to the single-configuration data cache/MMIO splitter in the MEM stage. Serves the pipeline's load/store handshake (r_valid/w_valid to r_ready/w_ready), and routes the I/O page straight to the IOU port. All other addresses go through an N-way set-associative, write-back, write-allocate cache with tree-PLRU replacement and a word-burst backing-memory port. Adds hit/miss statistics counters for SDU debug.

---
 rtl/dcache_mmio_nway.sv | 167 ++++++++++++++++
 tb/tb_dcache_mmio_nway.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mmio_nway.sv
// dcache_mmio_nway: MEM-stage N-way write-back data cache with tree-PLRU replacement and MMIO bypass
module dcache_mmio_nway #(
    parameter int DATA_W = 32,
    parameter int WAYS = 2,
    parameter int SETS = 16,
    parameter int LINE_WORDS = 4,
    parameter logic [DATA_W-9:0] IO_PAGE = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    input  logic              w_valid,
    output logic              r_ready,
    output logic              w_ready,
    output logic [DATA_W-1:0] r_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        io_addr,
    output logic [DATA_W-1:0] io_dout,
    input  logic [DATA_W-1:0] io_din,
    output logic              io_we,
    output logic              io_rd,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_W - OFF_W - IDX_W - 2;
    localparam int LOG_W = $clog2(WAYS);
    localparam int WAY_W = (LOG_W > 0) ? LOG_W : 1;
    localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [OFF_W-1:0]           cnt_q;
    logic [WAY_W-1:0]           vic_q;
    logic [WAYS-1:0][SETS-1:0]  valid_q, dirty_q;
    logic [SETS-1:0][PW-1:0]    plru_q;
    logic [TAG_W-1:0]           tag_q [WAYS][SETS];
    logic [DATA_W-1:0]          data_q [WAYS][SETS][LINE_WORDS];
    logic [31:0]                hit_q, miss_q;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             hit, io_page, in_idle, req, rd_only, mmio;
    logic             idle_hit, idle_miss, acc, last, fill_ack;
    logic [WAY_W-1:0] hit_way, victim, acc_way;

    // Tree PLRU: node n (heap order, root 1) lives at bit n-1; a bit of 1 means the right subtree is older.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] t);
        int n;
        n = 1;
        for (int l = 0; l < LOG_W; l++) n = 2 * n + int'(t[n-1]);
        return WAY_W'(n - WAYS);
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WAY_W-1:0] w);
        int   n;
        logic d;
        n = 1;
        for (int l = 0; l < LOG_W; l++) begin
            d = w[LOG_W-1-l];
            t[n-1] = ~d;
            n = 2 * n + int'(d);
        end
        return t;
    endfunction

    assign tag = addr[DATA_W-1 -: TAG_W];
    assign idx = addr[OFF_W+2 +: IDX_W];
    assign off = addr[2 +: OFF_W];

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        victim = plru_victim(plru_q[idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][idx]) victim = WAY_W'(w);
        end
    end

    assign io_page   = addr[DATA_W-1:8] == IO_PAGE;
    assign in_idle   = state_q == S_IDLE;
    assign req       = r_valid | w_valid;
    assign rd_only   = r_valid & ~w_valid;
    assign mmio      = in_idle & io_page;
    assign idle_hit  = in_idle & req & ~io_page & hit;
    assign idle_miss = in_idle & req & ~io_page & ~hit;
    assign acc       = idle_hit | (state_q == S_DONE);
    assign acc_way   = idle_hit ? hit_way : vic_q;
    assign last      = &cnt_q;
    assign fill_ack  = (state_q == S_FILL) & mem_ack;

    assign r_ready   = rd_only & (mmio | acc);
    assign w_ready   = w_valid & (mmio | acc);
    assign r_data    = !r_ready ? '0 : mmio ? io_din : data_q[acc_way][idx][off];
    assign io_rd     = mmio & rd_only;
    assign io_we     = mmio & w_valid;
    assign io_addr   = addr[7:0];
    assign io_dout   = w_data;
    assign mem_req   = (state_q == S_WB) | (state_q == S_FILL);
    assign mem_we    = state_q == S_WB;
    assign mem_addr  = mem_req ? {(mem_we ? tag_q[vic_q][idx] : tag), idx, cnt_q, 2'b00} : '0;
    assign mem_wdata = mem_we ? data_q[vic_q][idx][cnt_q] : '0;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

    always_comb begin
        state_d = idle_miss ? ((valid_q[victim][idx] & dirty_q[victim][idx]) ? S_WB : S_FILL)
                : (mem_we && mem_ack && last) ? S_FILL
                : (fill_ack && last) ? S_DONE
                : (state_q == S_DONE) ? S_IDLE : state_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vic_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            plru_q  <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            if (idle_miss) begin
                vic_q <= victim;
                cnt_q <= '0;
                miss_q <= miss_q + 32'd1;
                valid_q[victim][idx] <= 1'b0;
            end
            if (idle_hit) hit_q <= hit_q + 32'd1;
            if (acc) plru_q[idx] <= plru_touch(plru_q[idx], acc_way);
            if (acc && w_valid) dirty_q[acc_way][idx] <= 1'b1;
            if (mem_req && mem_ack) cnt_q <= cnt_q + 1'b1;
            if (mem_we && mem_ack && last) dirty_q[vic_q][idx] <= 1'b0;
            if (fill_ack && last) begin
                valid_q[vic_q][idx] <= 1'b1;
                dirty_q[vic_q][idx] <= 1'b0;
            end
        end
    end

    // Line storage carries no reset; validity alone decides whether its contents count.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (acc && w_valid) data_q[acc_way][idx][off] <= w_data;
            if (fill_ack) data_q[vic_q][idx][cnt_q] <= mem_rdata;
            if (fill_ack && last) tag_q[vic_q][idx] <= tag;
        end
    end
endmodule

// File: tb/tb_dcache_mmio_nway.sv
// tb_dcache_mmio_nway: randomized self-checking bench against a flat-memory plus LRU-set reference model
module tb_dcache_mmio_nway;
    logic        clk = 0, rstn = 0;
    logic [31:0] addr = 0, w_data = 0, mem_rdata = 0, io_din = 0;
    logic        r_valid = 0, w_valid = 0, mem_ack = 0;
    logic        r_ready, w_ready, mem_req, mem_we, io_we, io_rd;
    logic [31:0] r_data, mem_addr, mem_wdata, io_dout, hit_cnt, miss_cnt;
    logic [7:0]  io_addr;

    dcache_mmio_nway dut (
        .clk(clk), .rstn(rstn), .addr(addr), .w_data(w_data), .r_valid(r_valid), .w_valid(w_valid),
        .r_ready(r_ready), .w_ready(w_ready), .r_data(r_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din), .io_we(io_we), .io_rd(io_rd),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, ack_total = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] sh [logic [31:0]];
    logic [32:0] bursts[$], exp_b[$];
    bit          m_valid [2][16], m_dirty [2][16];
    logic [23:0] m_tag [2][16];
    int          m_mru [16];
    int          m_hits = 0, m_misses = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1010) return 32'hA0 + ((a - 32'h1000) >> 2);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] sh_rd(input logic [31:0] a);
        return sh.exists(a) ? sh[a] : init_val(a);
    endfunction

    // Backing memory: random-latency word acks, captured at the falling edge before the DUT samples them.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (rstn && mem_req && $urandom_range(0, 3) != 0) begin
            mem_ack = 1'b1;
            ack_total++;
            bursts.push_back({mem_we, mem_addr});
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem_rd(mem_addr);
        end
    end

    task automatic model_clear();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
            end
        for (int s = 0; s < 16; s++) m_mru[s] = 1;
        m_hits = 0;
        m_misses = 0;
        sh = mem;
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr, output bit hit);
        int v;
        logic [3:0] s;
        logic [23:0] t;
        s = a[7:4];
        t = a[31:8];
        hit = 0;
        v = 0;
        exp_b = {};
        for (int w = 0; w < 2; w++) if (m_valid[w][s] && m_tag[w][s] == t) begin hit = 1; v = w; end
        if (hit) m_hits++;
        else begin
            m_misses++;
            v = !m_valid[0][s] ? 0 : !m_valid[1][s] ? 1 : 1 - m_mru[s];
            if (m_valid[v][s] && m_dirty[v][s])
                for (int k = 0; k < 4; k++) exp_b.push_back({1'b1, m_tag[v][s], s, 2'(k), 2'b00});
            for (int k = 0; k < 4; k++) exp_b.push_back({1'b0, t, s, 2'(k), 2'b00});
            m_valid[v][s] = 1;
            m_tag[v][s] = t;
            m_dirty[v][s] = 0;
        end
        m_mru[s] = v;
        if (wr) m_dirty[v][s] = 1;
    endtask

    task automatic do_req(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d,
                          input string nm, output logic [31:0] got);
        bit io, exp_hit, done, bad;
        int lat;
        io = a[31:8] == 24'h0;
        exp_hit = 0;
        if (!io) model_access(a, wr, exp_hit);
        bursts = {};
        io_din = $urandom;
        got = 'x;
        @(posedge clk);
        #1;
        addr = a; w_data = d; w_valid = wr; r_valid = !wr || both;
        lat = 0;
        done = 0;
        while (!done && lat < 300) begin
            @(negedge clk);
            if (wr ? w_ready : r_ready) begin
                done = 1;
                got = r_data;
                if (both) begin
                    checks++;
                    if (r_ready !== 1'b0) begin failures++; $display("FAIL %s r_ready_on_dual got=%b want=0", nm, r_ready); end
                end
                if (io && wr) begin
                    checks++;
                    if ({io_we, io_addr, io_dout} !== {1'b1, a[7:0], d}) begin
                        failures++; $display("FAIL %s mmio_wr got we=%b addr=%h dout=%h want we=1 addr=%h dout=%h", nm, io_we, io_addr, io_dout, a[7:0], d);
                    end
                end else if (io) begin
                    checks++;
                    if ({io_rd, r_data} !== {1'b1, io_din}) begin
                        failures++; $display("FAIL %s mmio_rd got rd=%b data=%h want rd=1 data=%h", nm, io_rd, r_data, io_din);
                    end
                end else begin
                    checks++;
                    if ((lat == 0) != exp_hit) begin failures++; $display("FAIL %s hit_latency got lat=%0d want hit=%0b", nm, lat, exp_hit); end
                end
                if (!wr && !io) begin
                    checks++;
                    if (got !== sh_rd(a)) begin failures++; $display("FAIL %s load_data addr=%h got=%h want=%h", nm, a, got, sh_rd(a)); end
                end
            end else lat++;
        end
        @(posedge clk);
        #1;
        r_valid = 0; w_valid = 0;
        checks++;
        if (!done) begin failures++; $display("FAIL %s timeout addr=%h got=no_ready want=ready", nm, a); end
        if (wr && !io) sh[a] = d;
        if (!io) begin
            bad = bursts.size() != exp_b.size();
            for (int i = 0; i < bursts.size() && !bad; i++) bad = bursts[i] !== exp_b[i];
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s burst_seq got n=%0d first=%h want n=%0d first=%h", nm, bursts.size(),
                         bursts.size() ? bursts[0] : 33'h0, exp_b.size(), exp_b.size() ? exp_b[0] : 33'h0);
            end
        end
        checks++;
        if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
            failures++; $display("FAIL %s counters got hit=%0d miss=%0d want hit=%0d miss=%0d", nm, hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic test_reset();
        rstn = 0; r_valid = 0; w_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({r_ready, w_ready, mem_req, mem_we, io_we, io_rd} !== 6'b0) begin
            failures++; $display("FAIL reset_strobes got=%b want=000000", {r_ready, w_ready, mem_req, mem_we, io_we, io_rd});
        end
        checks++;
        if ({r_data, mem_addr, mem_wdata, hit_cnt, miss_cnt} !== 160'h0) begin
            failures++; $display("FAIL reset_values got r_data=%h mem_addr=%h wdata=%h hit=%0d miss=%0d want all 0", r_data, mem_addr, mem_wdata, hit_cnt, miss_cnt);
        end
        rstn = 1;
        model_clear();
    endtask

    task automatic test_cold_and_hit();
        logic [31:0] got;
        do_req(0, 0, 32'h1000, 0, "cold_load", got);
        checks++;
        if (got !== 32'hA0 || miss_cnt !== 1 || hit_cnt !== 0) begin
            failures++; $display("FAIL cold_load_plan got data=%h miss=%0d hit=%0d want data=a0 miss=1 hit=0", got, miss_cnt, hit_cnt);
        end
        do_req(0, 0, 32'h1008, 0, "hit_after_fill", got);
        checks++;
        if (got !== 32'hA2 || hit_cnt !== 1) begin
            failures++; $display("FAIL hit_plan got data=%h hit=%0d want data=a2 hit=1", got, hit_cnt);
        end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] got;
        do_req(1, 0, 32'h1000, 32'hDEAD, "store_hit", got);
        do_req(0, 0, 32'h1400, 0, "load_way1", got);
        do_req(0, 0, 32'h1800, 0, "evict_load", got);
        checks++;
        if (bursts.size() < 5 || bursts[0] !== {1'b1, 32'h1000} || bursts[4] !== {1'b0, 32'h1800} || mem_rd(32'h1000) !== 32'hDEAD) begin
            failures++; $display("FAIL evict_plan got first=%h mem1000=%h want first=1_00001000 fill=0_00001800 mem1000=dead",
                                 bursts.size() ? bursts[0] : 33'h0, mem_rd(32'h1000));
        end
        do_req(0, 0, 32'h1000, 0, "reload_dirty", got);
    endtask

    task automatic test_mmio();
        logic [31:0] got;
        do_req(1, 0, 32'h4, 32'h55, "mmio_store", got);
        do_req(0, 0, 32'h8, 0, "mmio_load", got);
    endtask

    task automatic test_dual_valid();
        logic [31:0] got;
        do_req(1, 1, 32'h1804, 32'hBEEF, "dual_valid", got);
        do_req(0, 0, 32'h1804, 0, "dual_readback", got);
    endtask

    task automatic test_random();
        logic [31:0] got, a;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, 63)) << 2;
            else a = {8'h0, 16'h0010 + 16'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00} >> 2 << 2;
            if (a[31:8] != 0) a = {16'h0, 8'h10 + 8'($urandom_range(0, 5)), 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            do_req($urandom_range(0, 1), 0, a, $urandom, "random", got);
        end
    endtask

    task automatic test_reset_midfill();
        logic [31:0] got;
        int base, n;
        rstn = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        model_clear();
        base = ack_total;
        addr = 32'h2040; r_valid = 1;
        n = 0;
        while (ack_total - base < 2 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (mem_req !== 1'b1 || ack_total - base != 2) begin
            failures++; $display("FAIL midfill_reach got req=%b acks=%0d want req=1 acks=2", mem_req, ack_total - base);
        end
        rstn = 0; r_valid = 0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL midfill_abort got mem_req=%b want=0", mem_req); end
        rstn = 1;
        model_clear();
        do_req(0, 0, 32'h2040, 0, "after_abort", got);
        checks++;
        if (miss_cnt !== 1) begin failures++; $display("FAIL after_abort_miss got=%0d want=1", miss_cnt); end
    endtask

    initial begin
        test_reset();
        test_cold_and_hit();
        test_dirty_evict();
        test_mmio();
        test_dual_valid();
        test_random();
        test_reset_midfill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
